// File: rtl/s16_dmem_ctrl.sv
// Data-memory controller for the S16 multi-cycle CPU: handshaked load/store with wait states.
// Optional MMIO (gpio_out at 0xFFFF, cycle counter at 0xFFFE) enabled by S16_DMEM_MMIO_EN.
module s16_dmem_ctrl #(
    parameter int AW   = 8,
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
`ifdef S16_DMEM_MMIO_EN
    ,
    output logic [15:0] gpio_out
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'((WAIT > 0) ? WAIT - 1 : 0);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          mmio_q, mmio_d;

    logic [15:0]   ram [0:(1<<AW)-1];
    logic          accept;
    logic          in_range;
    logic          mmio_req;
    logic [15:0]   access_rdata;

`ifdef S16_DMEM_MMIO_EN
    logic          gpio_sel_q, gpio_sel_d;
    logic [15:0]   gpio_q, gpio_d;
    logic [15:0]   cyc_q, cyc_d;

    assign mmio_req     = (req_addr == 16'hFFFF) || (req_addr == 16'hFFFE);
    assign access_rdata = mmio_q ? (gpio_sel_q ? gpio_q : cyc_q) : ram[addr_q];
    assign gpio_out     = gpio_q;
`else
    assign mmio_req     = 1'b0;
    assign access_rdata = ram[addr_q];
`endif

    assign accept   = req_valid && (state_q == S_IDLE);
    assign in_range = (req_addr[15:AW] == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_range && !mmio_req) state_d = S_RESP;
                    else if (WAIT > 0)          state_d = S_WAIT;
                    else                        state_d = S_ACCESS;
                end
            end
            S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Request capture, wait counter and response registers
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mmio_d  = mmio_q;
        if (accept) begin
            cnt_d   = CNT_INIT;
            rdata_d = 16'h0000;
            err_d   = !in_range && !mmio_req;
            we_d    = req_we;
            addr_d  = req_addr[AW-1:0];
            wdata_d = req_wdata;
            mmio_d  = mmio_req;
        end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else if (state_q == S_ACCESS) begin
            rdata_d = we_q ? 16'h0000 : access_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        mmio_q  <= mmio_d;
    end

    // An aborted request never reaches ACCESS, so reset alone protects the RAM
    always_ff @(posedge clk) begin
        if (state_q == S_ACCESS && we_q && !mmio_q) begin
            ram[addr_q] <= wdata_q;
        end
    end

`ifdef S16_DMEM_MMIO_EN
    always_comb begin
        gpio_sel_d = gpio_sel_q;
        gpio_d     = gpio_q;
        cyc_d      = cyc_q + 16'd1;
        if (accept) begin
            gpio_sel_d = (req_addr == 16'hFFFF);
        end
        if (state_q == S_ACCESS && we_q && mmio_q && gpio_sel_q) begin
            gpio_d = wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q <= 16'h0000;
            cyc_q  <= 16'h0000;
        end else begin
            gpio_q <= gpio_d;
            cyc_q  <= cyc_d;
        end
    end

    always_ff @(posedge clk) begin
        gpio_sel_q <= gpio_sel_d;
    end
`endif

endmodule

// File: tb/tb_s16_dmem_ctrl.sv
// Directed bench for s16_dmem_ctrl: one instance with WAIT=0 and one with WAIT=3,
// sharing request buses; sel chooses which instance gets req_valid and is observed.
module tb_s16_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        sel = 1'b0;

    logic        rdy0, rv0, err0, busy0, rdy3, rv3, err3, busy3;
    logic [15:0] rd0, rd3;
`ifdef S16_DMEM_MMIO_EN
    logic [15:0] gpio0, gpio3;
`endif

    logic        req_ready, resp_valid, resp_err, busy;
    logic [15:0] resp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    s16_dmem_ctrl #(.AW(8), .WAIT(0)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy0),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .busy(busy0)
`ifdef S16_DMEM_MMIO_EN
        , .gpio_out(gpio0)
`endif
    );

    s16_dmem_ctrl #(.AW(8), .WAIT(3)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy3),
        .resp_valid(rv3), .resp_rdata(rd3), .resp_err(err3), .busy(busy3)
`ifdef S16_DMEM_MMIO_EN
        , .gpio_out(gpio3)
`endif
    );

    assign req_ready  = sel ? rdy3 : rdy0;
    assign resp_valid = sel ? rv3  : rv0;
    assign resp_rdata = sel ? rd3  : rd0;
    assign resp_err   = sel ? err3 : err0;
    assign busy       = sel ? busy3 : busy0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request; lat counts rising edges from the accept edge to the first observation of resp_valid
    task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output logic er, output int lat);
        logic saw_ready, saw_idle;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        check("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 16'hDEAD; req_wdata = 16'hDEAD; req_we = ~we;
        lat = 1;
        saw_ready = req_ready;
        saw_idle  = !busy;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            saw_ready = saw_ready | req_ready;
            saw_idle  = saw_idle | !busy;
        end
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        rd = resp_rdata;
        er = resp_err;
        check("ready_low_while_busy", {31'd0, saw_ready}, 32'd0);
        check("busy_high_while_busy", {31'd0, saw_idle}, 32'd0);
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [15:0] rd, c1, c2;
        logic        er;
        int          lat, pulses, k, cyc;
        logic        rdy;

        #1;
        check("rst_ready0", {31'd0, rdy0}, 32'd1);
        check("rst_rv0",    {31'd0, rv0},  32'd0);
        check("rst_rdata0", {16'd0, rd0},  32'd0);
        check("rst_err0",   {31'd0, err0}, 32'd0);
        check("rst_busy0",  {31'd0, busy0}, 32'd0);
        check("rst_busy3",  {31'd0, busy3}, 32'd0);
`ifdef S16_DMEM_MMIO_EN
        check("rst_gpio", {16'd0, gpio0}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // WAIT=0: store then load
        sel = 1'b0;
        do_req(1'b1, 16'h0005, 16'h1234, rd, er, lat);
        check("t1_st_lat", 32'(lat), 32'd2);
        check("t1_st_err", {31'd0, er}, 32'd0);
        check("t1_st_rdata", {16'd0, rd}, 32'd0);
        do_req(1'b0, 16'h0005, 16'h0000, rd, er, lat);
        check("t1_ld_lat", 32'(lat), 32'd2);
        check("t1_ld_rdata", {16'd0, rd}, 32'h1234);
        check("t1_ld_err", {31'd0, er}, 32'd0);

        // WAIT=3 latency
        sel = 1'b1;
        do_req(1'b1, 16'h0010, 16'hC0DE, rd, er, lat);
        check("t2_st_lat", 32'(lat), 32'd5);
        do_req(1'b0, 16'h0010, 16'h0000, rd, er, lat);
        check("t2_ld_lat", 32'(lat), 32'd5);
        check("t2_ld_rdata", {16'd0, rd}, 32'hC0DE);

        // Out-of-range accesses
        sel = 1'b0;
        do_req(1'b1, 16'h0000, 16'h5A5A, rd, er, lat);
        do_req(1'b0, 16'h0100, 16'h0000, rd, er, lat);
        check("t3_err", {31'd0, er}, 32'd1);
        check("t3_err_rdata", {16'd0, rd}, 32'd0);
        check("t3_err_lat", 32'(lat), 32'd1);
        do_req(1'b1, 16'h0100, 16'hFFFF, rd, er, lat);
        check("t3_st_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 16'h8000, 16'h0000, rd, er, lat);
        check("t3_hibit_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 16'h0000, 16'h0000, rd, er, lat);
        check("t3_ram_unchanged", {16'd0, rd}, 32'h5A5A);
        check("t3_ok_err", {31'd0, er}, 32'd0);

        // Reset while a store sits in WAIT
        sel = 1'b1;
        do_req(1'b1, 16'h0007, 16'h1111, rd, er, lat);
        @(negedge clk);
        req_we = 1'b1; req_addr = 16'h0007; req_wdata = 16'hAAAA; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t4_in_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("t4_rst_ready", {31'd0, req_ready}, 32'd1);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
        end
        check("t4_no_resp", 32'(pulses), 32'd0);
        do_req(1'b0, 16'h0007, 16'h0000, rd, er, lat);
        check("t4_old_data", {16'd0, rd}, 32'h1111);

        // MMIO
        sel = 1'b0;
`ifdef S16_DMEM_MMIO_EN
        do_req(1'b1, 16'hFFFF, 16'hBEEF, rd, er, lat);
        check("t5_gpio", {16'd0, gpio0}, 32'hBEEF);
        check("t5_gpio_err", {31'd0, er}, 32'd0);
        check("t5_gpio_lat", 32'(lat), 32'd2);
        do_req(1'b0, 16'hFFFF, 16'h0000, rd, er, lat);
        check("t5_gpio_rd", {16'd0, rd}, 32'hBEEF);
        do_req(1'b0, 16'hFFFE, 16'h0000, c1, er, lat);
        check("t5_cyc_err", {31'd0, er}, 32'd0);
        do_req(1'b1, 16'hFFFE, 16'h0000, rd, er, lat);
        do_req(1'b0, 16'hFFFE, 16'h0000, c2, er, lat);
        check("t5_cyc_inc", {31'd0, (c2 > c1)}, 32'd1);
`else
        do_req(1'b1, 16'hFFFF, 16'hBEEF, rd, er, lat);
        check("t5_ffff_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 16'hFFFE, 16'h0000, rd, er, lat);
        check("t5_fffe_err", {31'd0, er}, 32'd1);
        check("t5_fffe_rdata", {16'd0, rd}, 32'd0);
`endif

        // Back-to-back stores with req_valid held high
        sel = 1'b0;
        @(negedge clk);
        k = 0; pulses = 0; cyc = 0;
        req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h0A00; req_valid = 1'b1;
        while (k < 4 && cyc < 100) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy) begin
                k++;
                if (k < 4) begin
                    req_addr  = 16'h0020 + 16'(k);
                    req_wdata = 16'h0A00 + 16'(k);
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (resp_valid) pulses++;
            cyc++;
            @(negedge clk);
        end
        check("t6_accepts", 32'(k), 32'd4);
        check("t6_cycles", 32'(cyc), 32'd10);
        repeat (6) begin
            @(posedge clk); #1;
            if (resp_valid) pulses++;
        end
        check("t6_pulses", 32'(pulses), 32'd4);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 16'h0020 + 16'(i), 16'h0000, rd, er, lat);
            check("t6_data", {16'd0, rd}, {16'd0, 16'h0A00 + 16'(i)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
